// File: rtl/pattern_tx_1010_if.sv
// Request/transmit bundle for pattern_tx_1010: request handshake plus serial outputs.
interface pattern_tx_1010_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             start_valid;
  logic             start_ready;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] count;
  logic             q;
  logic             q_valid;
  logic             busy;
  logic             done;

  modport master (
    output start_valid, pattern, count,
    input  start_ready, q, q_valid, busy, done
  );

  modport slave (
    input  start_valid, pattern, count,
    output start_ready, q, q_valid, busy, done
  );
endinterface

// File: rtl/pattern_tx_1010.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first, count times,
// with GAP idle cycles between repetitions and a one-cycle done pulse at the end.
module pattern_tx_1010 #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP   = 2
) (
  input  logic               clk,
  input  logic               reset,
  pattern_tx_1010_if.slave   bus
);
  localparam int IW = $clog2(PAT_W);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [IW-1:0]    IDX_LOAD = IW'(PAT_W - 1);
  localparam logic [GW-1:0]    GAP_LOAD = GW'((GAP > 0) ? (GAP - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [1:0]       state_r;
  logic [PAT_W-1:0] pat_r;
  logic [CNT_W-1:0] cnt_r;
  logic [IW-1:0]    idx_r;
  logic [GW-1:0]    gap_r;
  logic             q_r;
  logic             q_valid_r;
  logic             busy_r;
  logic             done_r;
  logic             start_ready_s;
  logic             accept_s;

  assign start_ready_s   = (state_r == S_IDLE);
  assign accept_s        = bus.start_valid & start_ready_s;
  assign bus.start_ready = start_ready_s;
  assign bus.q           = q_r;
  assign bus.q_valid     = q_valid_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;

  // Transfer FSM; outputs are registered and set on entry to each state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= S_IDLE;
      pat_r     <= '0;
      cnt_r     <= '0;
      idx_r     <= '0;
      gap_r     <= '0;
      q_r       <= 1'b0;
      q_valid_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            pat_r  <= bus.pattern;
            cnt_r  <= bus.count;
            idx_r  <= IDX_LOAD;
            busy_r <= 1'b1;
            if (bus.count == CNT_ZERO) begin
              state_r <= S_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r   <= S_SHIFT;
              q_r       <= bus.pattern[PAT_W-1];
              q_valid_r <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          if (idx_r == '0) begin
            if (cnt_r == CNT_ONE) begin
              // Last repetition: no trailing gap.
              state_r   <= S_DONE;
              q_r       <= 1'b0;
              q_valid_r <= 1'b0;
              done_r    <= 1'b1;
            end else if (GAP > 0) begin
              state_r   <= S_GAP;
              cnt_r     <= cnt_r - CNT_ONE;
              gap_r     <= GAP_LOAD;
              q_r       <= 1'b0;
              q_valid_r <= 1'b0;
            end else begin
              cnt_r     <= cnt_r - CNT_ONE;
              idx_r     <= IDX_LOAD;
              q_r       <= pat_r[PAT_W-1];
              q_valid_r <= 1'b1;
            end
          end else begin
            idx_r <= idx_r - 1'b1;
            q_r   <= pat_r[idx_r - 1'b1];
          end
        end
        S_GAP: begin
          if (gap_r == '0) begin
            state_r   <= S_SHIFT;
            idx_r     <= IDX_LOAD;
            q_r       <= pat_r[PAT_W-1];
            q_valid_r <= 1'b1;
          end else begin
            gap_r <= gap_r - 1'b1;
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r   <= S_IDLE;
          q_r       <= 1'b0;
          q_valid_r <= 1'b0;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pattern_tx_1010.sv
// Self-checking bench: three transmitter instances (GAP=2, GAP=0, CNT_W=3/GAP=1)
// compared cycle by cycle against a frame-timing model built from arithmetic.
module tb_pattern_tx_1010;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       drv_valid [3];
  logic [3:0] drv_pat   [3];
  logic [7:0] drv_cnt   [3];
  logic [4:0] obs       [3];   // {start_ready, busy, done, q_valid, q}
  int         gap_of    [3] = '{2, 0, 1};
  int         n_pass = 0;
  int         n_total = 0;

  always #5 clk = ~clk;

  pattern_tx_1010_if #(.PAT_W(4), .CNT_W(8)) if_a ();
  pattern_tx_1010_if #(.PAT_W(4), .CNT_W(8)) if_b ();
  pattern_tx_1010_if #(.PAT_W(4), .CNT_W(3)) if_c ();

  pattern_tx_1010 #(.PAT_W(4), .CNT_W(8), .GAP(2)) dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
  pattern_tx_1010 #(.PAT_W(4), .CNT_W(8), .GAP(0)) dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));
  pattern_tx_1010 #(.PAT_W(4), .CNT_W(3), .GAP(1)) dut_c (.clk(clk), .reset(reset), .bus(if_c.slave));

  assign if_a.start_valid = drv_valid[0];
  assign if_a.pattern     = drv_pat[0];
  assign if_a.count       = drv_cnt[0];
  assign if_b.start_valid = drv_valid[1];
  assign if_b.pattern     = drv_pat[1];
  assign if_b.count       = drv_cnt[1];
  assign if_c.start_valid = drv_valid[2];
  assign if_c.pattern     = drv_pat[2];
  assign if_c.count       = drv_cnt[2][2:0];
  assign obs[0] = {if_a.start_ready, if_a.busy, if_a.done, if_a.q_valid, if_a.q};
  assign obs[1] = {if_b.start_ready, if_b.busy, if_b.done, if_b.q_valid, if_b.q};
  assign obs[2] = {if_c.start_ready, if_c.busy, if_c.done, if_c.q_valid, if_c.q};

  // Expected outputs t cycles after the accept edge, from frame arithmetic.
  function automatic logic [4:0] exp_vec(input logic [3:0] pat, input int cnt, input int gap, input int t);
    int len;
    int pos;
    logic q, qv, dn, bz, rd;
    len = (cnt == 0) ? 0 : cnt * 4 + (cnt - 1) * gap;
    q = 1'b0; qv = 1'b0; dn = 1'b0; bz = 1'b0; rd = 1'b1;
    if (t <= len) begin
      pos = (t - 1) % (4 + gap);
      bz = 1'b1; rd = 1'b0;
      if (pos < 4) begin
        qv = 1'b1;
        q  = pat[3 - pos];
      end
    end else if (t == len + 1) begin
      dn = 1'b1; bz = 1'b1; rd = 1'b0;
    end
    return {rd, bz, dn, qv, q};
  endfunction

  function automatic int frame_len(input int cnt, input int gap);
    return (cnt == 0) ? 0 : cnt * 4 + (cnt - 1) * gap;
  endfunction

  // Waits (bounded) for start_ready, then presents one request across a clock edge.
  task automatic do_accept(input int k, input logic [3:0] pat, input logic [7:0] cnt);
    int w = 0;
    while (obs[k][4] !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    n_total++;
    if (obs[k][4] !== 1'b1) $display("FAIL accept_wait dut%0d: start_ready=%b required 1", k, obs[k][4]);
    else n_pass++;
    drv_pat[k] = pat;
    drv_cnt[k] = cnt;
    drv_valid[k] = 1'b1;
    @(posedge clk);
    #1 drv_valid[k] = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) drv_valid[k] = 1'b1;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        n_total++;
        if (obs[k] !== 5'b10000) $display("FAIL reset dut%0d cyc%0d: got %b want 10000", k, c, obs[k]);
        else n_pass++;
      end
    end
    for (int k = 0; k < 3; k++) drv_valid[k] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [4:0] e;
    do_accept(0, 4'b1010, 8'd3);
    for (int t = 1; t <= frame_len(3, 2) + 2; t++) begin
      @(negedge clk);
      e = exp_vec(4'b1010, 3, 2, t);
      n_total++;
      if (obs[0] !== e) $display("FAIL basic t=%0d: got %b want %b", t, obs[0], e);
      else n_pass++;
    end
  endtask

  task automatic test_gap0();
    logic [4:0] e;
    do_accept(1, 4'b1010, 8'd2);
    for (int t = 1; t <= frame_len(2, 0) + 2; t++) begin
      @(negedge clk);
      e = exp_vec(4'b1010, 2, 0, t);
      n_total++;
      if (obs[1] !== e) $display("FAIL gap0 t=%0d: got %b want %b", t, obs[1], e);
      else n_pass++;
    end
  endtask

  task automatic test_zero_count_and_churn();
    logic [4:0] e;
    do_accept(0, 4'b1111, 8'd0);
    for (int t = 1; t <= 2; t++) begin
      @(negedge clk);
      e = exp_vec(4'b1111, 0, 2, t);
      n_total++;
      if (obs[0] !== e) $display("FAIL zero_count t=%0d: got %b want %b", t, obs[0], e);
      else n_pass++;
    end
    do_accept(0, 4'b1100, 8'd1);
    for (int t = 1; t <= frame_len(1, 2) + 2; t++) begin
      @(negedge clk);
      e = exp_vec(4'b1100, 1, 2, t);
      n_total++;
      if (obs[0] !== e) $display("FAIL churn t=%0d: got %b want %b", t, obs[0], e);
      else n_pass++;
      if (t == 2) begin
        drv_pat[0] = 4'b0011;
        drv_cnt[0] = 8'd5;
        drv_valid[0] = 1'b1;
      end else if (t == 4) begin
        drv_valid[0] = 1'b0;
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [4:0] e;
    logic [3:0] p;
    do_accept(0, 4'b1010, 8'd5);
    for (int t = 1; t <= 5; t++) begin
      @(negedge clk);
      e = exp_vec(4'b1010, 5, 2, t);
      n_total++;
      if (obs[0] !== e) $display("FAIL mid_reset_pre t=%0d: got %b want %b", t, obs[0], e);
      else n_pass++;
    end
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    n_total++;
    if (obs[0] !== 5'b10000) $display("FAIL mid_reset_async: got %b want 10000", obs[0]);
    else n_pass++;
    repeat (2) begin
      @(negedge clk);
      n_total++;
      if (obs[0] !== 5'b10000) $display("FAIL mid_reset_hold: got %b want 10000", obs[0]);
      else n_pass++;
    end
    reset = 1'b1;
    @(negedge clk);
    n_total++;
    if (obs[0] !== 5'b10000) $display("FAIL mid_reset_release: got %b want 10000", obs[0]);
    else n_pass++;
    p = 4'($urandom_range(8, 15));
    do_accept(0, p, 8'd2);
    for (int t = 1; t <= frame_len(2, 2) + 2; t++) begin
      @(negedge clk);
      e = exp_vec(p, 2, 2, t);
      n_total++;
      if (obs[0] !== e) $display("FAIL mid_reset_restart t=%0d: got %b want %b", t, obs[0], e);
      else n_pass++;
    end
  endtask

  task automatic test_max_count();
    logic [4:0] e;
    int nvalid = 0;
    do_accept(2, 4'b1010, 8'd7);
    for (int t = 1; t <= frame_len(7, 1) + 2; t++) begin
      @(negedge clk);
      e = exp_vec(4'b1010, 7, 1, t);
      if (obs[2][1] === 1'b1) nvalid++;
      n_total++;
      if (obs[2] !== e) $display("FAIL max_count3 t=%0d: got %b want %b", t, obs[2], e);
      else n_pass++;
    end
    n_total++;
    if (nvalid != 28) $display("FAIL max_count3_bits: got %0d valid bits want 28", nvalid);
    else n_pass++;
    do_accept(0, 4'b0110, 8'd255);
    for (int t = 1; t <= frame_len(255, 2) + 2; t++) begin
      @(negedge clk);
      e = exp_vec(4'b0110, 255, 2, t);
      n_total++;
      if (obs[0] !== e) $display("FAIL max_count8 t=%0d: got %b want %b", t, obs[0], e);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back_random();
    logic [4:0] e;
    logic [3:0] p;
    int c;
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 6; n++) begin
        p = 4'($urandom_range(0, 15));
        c = (k == 2) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 4));
        do_accept(k, p, 8'(c));
        for (int t = 1; t <= frame_len(c, gap_of[k]) + 2; t++) begin
          @(negedge clk);
          e = exp_vec(p, c, gap_of[k], t);
          n_total++;
          if (obs[k] !== e) $display("FAIL random dut%0d pat=%b cnt=%0d t=%0d: got %b want %b", k, p, c, t, obs[k], e);
          else n_pass++;
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      drv_valid[k] = 1'b0;
      drv_pat[k]   = 4'b0000;
      drv_cnt[k]   = 8'd0;
    end
    test_reset();
    test_basic();
    test_gap0();
    test_zero_count_and_churn();
    test_mid_reset();
    test_max_count();
    test_back_to_back_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
